// File: rtl/rst_seq.sv
// rst_seq: power-up / recovery reset sequencer for the Ethernet board.
// Waits for a synchronized PLL lock, then releases the PHY, the MAC and the
// application logic in that order, with a programmable dwell in each step.
// A lock loss or a software reset request restarts the whole sequence.
module rst_seq #(
   parameter int PHY_RST_CYCLES  = 1000,
   parameter int PHY_WAIT_CYCLES = 5000,
   parameter int MAC_WAIT_CYCLES = 16,
   parameter int CNT_W           = 16
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       pll_locked_i,
   input  logic       sw_rst_i,
   output logic       phy_rst_n_o,
   output logic       mac_rst_o,
   output logic       app_rst_o,
   output logic       ready_o,
   output logic [2:0] state_o,
   output logic [7:0] lock_loss_cnt_o
);

   typedef enum logic [2:0] {
      HOLD      = 3'd0,
      WAIT_LOCK = 3'd1,
      PHY_RST   = 3'd2,
      PHY_WAIT  = 3'd3,
      MAC_WAIT  = 3'd4,
      RUN       = 3'd5
   } state_t;

   // Dwell reload values: a state lasting N cycles starts its count at N-1
   // and leaves on the edge that sees the counter at zero.
   localparam logic [CNT_W-1:0] PHY_RST_LOAD  = CNT_W'(PHY_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] PHY_WAIT_LOAD = CNT_W'(PHY_WAIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] MAC_WAIT_LOAD = CNT_W'(MAC_WAIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
   logic             cnt_zero;
   logic             lock_meta;
   logic             lock_s;
   logic             lock_loss;

   assign cnt_zero = (cnt == '0);
   assign state_o  = state;

   // Two-flop synchronizer for the asynchronous PLL lock indication.
   always_ff @(posedge clk_i) begin
      // NOTE: clocked state uses non-blocking assignments so every flop samples
      // the pre-edge values; blocking here would collapse the two stages.
      if (rst_i) begin
         lock_meta <= 1'b0;
         lock_s    <= 1'b0;
      end else begin
         lock_meta <= pll_locked_i;
         lock_s    <= lock_meta;
      end
   end

   // Next-state decode; software reset outranks lock loss, which outranks
   // normal progress. Only lock-driven exits are flagged for the counter.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can
      // leave a signal unassigned and infer a latch.
      state_next = state;
      lock_loss  = 1'b0;
      if (sw_rst_i) begin
         state_next = HOLD;
      end else begin
         case (state)
            HOLD: begin
               state_next = WAIT_LOCK;
            end
            WAIT_LOCK: begin
               if (lock_s) state_next = PHY_RST;
            end
            PHY_RST: begin
               if (!lock_s) begin
                  state_next = HOLD;
                  lock_loss  = 1'b1;
               end else if (cnt_zero) begin
                  state_next = PHY_WAIT;
               end
            end
            PHY_WAIT: begin
               if (!lock_s) begin
                  state_next = HOLD;
                  lock_loss  = 1'b1;
               end else if (cnt_zero) begin
                  state_next = MAC_WAIT;
               end
            end
            MAC_WAIT: begin
               if (!lock_s) begin
                  state_next = HOLD;
                  lock_loss  = 1'b1;
               end else if (cnt_zero) begin
                  state_next = RUN;
               end
            end
            RUN: begin
               if (!lock_s) begin
                  state_next = HOLD;
                  lock_loss  = 1'b1;
               end
            end
            default: begin
               // Codes 6 and 7 can only come from an upset; recover safely.
               state_next = HOLD;
            end
         endcase
      end
   end

   // Dwell counter decode: reload on entry to a timed state, otherwise count
   // down to zero and rest there.
   always_comb begin
      cnt_next = cnt;
      if (state_next != state) begin
         case (state_next)
            PHY_RST:  cnt_next = PHY_RST_LOAD;
            PHY_WAIT: cnt_next = PHY_WAIT_LOAD;
            MAC_WAIT: cnt_next = MAC_WAIT_LOAD;
            default:  cnt_next = '0;
         endcase
      end else if (!cnt_zero) begin
         cnt_next = cnt - CNT_ONE;
      end
   end

   // State, counter and reset outputs; outputs decode the next state so they
   // move on the same edge as state_o.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= HOLD;
         cnt         <= '0;
         phy_rst_n_o <= 1'b0;
         mac_rst_o   <= 1'b1;
         app_rst_o   <= 1'b1;
         ready_o     <= 1'b0;
      end else begin
         state       <= state_next;
         cnt         <= cnt_next;
         phy_rst_n_o <= (state_next == PHY_WAIT) || (state_next == MAC_WAIT) ||
                        (state_next == RUN);
         mac_rst_o   <= !((state_next == MAC_WAIT) || (state_next == RUN));
         app_rst_o   <= (state_next != RUN);
         ready_o     <= (state_next == RUN);
      end
   end

   // Saturating count of restarts caused by losing PLL lock.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lock_loss_cnt_o <= 8'd0;
      end else if (lock_loss && (lock_loss_cnt_o != 8'hFF)) begin
         lock_loss_cnt_o <= lock_loss_cnt_o + 8'd1;
      end
   end

   // Release-order invariants seen by the downstream blocks.
   a_mac_after_phy: assert property (@(posedge clk_i) disable iff (rst_i)
      !phy_rst_n_o |-> mac_rst_o);
   a_app_after_mac: assert property (@(posedge clk_i) disable iff (rst_i)
      mac_rst_o |-> app_rst_o);
   a_ready_is_run: assert property (@(posedge clk_i) disable iff (rst_i)
      ready_o == !app_rst_o);
   a_phy_needs_lock: assert property (@(posedge clk_i) disable iff (rst_i)
      $rose(phy_rst_n_o) |-> $past(lock_s));

endmodule
